// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: hunts for SYNC_WORD, reads a length word, forwards indexed payload words and
// reports per-frame done/error. Define UART_FRAME_CHECKSUM_EN to require a trailing checksum word.
module uart_frame_ctrl #(
    parameter int               WIDTH          = 16,
    parameter logic [WIDTH-1:0] SYNC_WORD      = 16'hA55A,
    parameter int               MAX_LEN        = 64,
    parameter int               TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rx_valid_in,
    input  logic [WIDTH-1:0]             rx_data_in,
    output logic                         word_valid_out,
    output logic [WIDTH-1:0]             word_data_out,
    output logic [$clog2(MAX_LEN)-1:0]   word_index_out,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len_out,
    output logic                         frame_done_out,
    output logic                         frame_err_out,
    output logic [1:0]                   err_code_out,
    output logic                         busy_out
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WIDTH-1:0] MAX_LEN_W   = WIDTH'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       ERR_TIMEOUT = 2'd1;
    localparam logic [1:0]       ERR_LEN     = 2'd2;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [1:0]       ERR_SUM     = 2'd3;
`endif

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;

    state_t           state_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [IDX_W-1:0] idx_reg;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [WIDTH-1:0] sum_reg;
`else
    logic             done_pend_reg;
`endif

    logic timeout_hit;
    logic last_word;
    logic len_ok;

    // A word arriving on the boundary cycle takes priority over the timeout.
    assign timeout_hit = (state_reg != HUNT) && !rx_valid_in && (tmo_cnt_reg == TMO_LAST);
    assign last_word   = (LEN_W'(idx_reg) + LEN_W'(1)) == frame_len_out;
    assign len_ok      = (rx_data_in != '0) && (rx_data_in <= MAX_LEN_W);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg      <= HUNT;
            tmo_cnt_reg    <= '0;
            idx_reg        <= '0;
            word_valid_out <= 1'b0;
            word_data_out  <= '0;
            word_index_out <= '0;
            frame_len_out  <= '0;
            frame_done_out <= 1'b0;
            frame_err_out  <= 1'b0;
            err_code_out   <= '0;
            busy_out       <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_reg        <= '0;
`else
            done_pend_reg  <= 1'b0;
`endif
        end else begin
            word_valid_out <= 1'b0;
            frame_err_out  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            frame_done_out <= 1'b0;
`else
            // Done trails the last payload pulse by one cycle; the FSM is already back in HUNT.
            frame_done_out <= done_pend_reg;
            done_pend_reg  <= 1'b0;
            if (done_pend_reg) begin
                err_code_out <= '0;
            end
`endif
            if (state_reg == HUNT || rx_valid_in) begin
                tmo_cnt_reg <= '0;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end

            if (timeout_hit) begin
                frame_err_out <= 1'b1;
                err_code_out  <= ERR_TIMEOUT;
                state_reg     <= HUNT;
                busy_out      <= 1'b0;
            end else if (rx_valid_in) begin
                case (state_reg)
                    HUNT: begin
                        if (rx_data_in == SYNC_WORD) begin
                            state_reg <= LEN;
                            busy_out  <= 1'b1;
                        end
                    end
                    LEN: begin
                        if (len_ok) begin
                            frame_len_out <= LEN_W'(rx_data_in);
                            idx_reg       <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                            sum_reg       <= rx_data_in;
`endif
                            state_reg     <= PAYLOAD;
                        end else begin
                            frame_err_out <= 1'b1;
                            err_code_out  <= ERR_LEN;
                            state_reg     <= HUNT;
                            busy_out      <= 1'b0;
                        end
                    end
                    PAYLOAD: begin
                        word_valid_out <= 1'b1;
                        word_data_out  <= rx_data_in;
                        word_index_out <= idx_reg;
                        idx_reg        <= idx_reg + IDX_W'(1);
`ifdef UART_FRAME_CHECKSUM_EN
                        sum_reg        <= sum_reg + rx_data_in;
                        if (last_word) begin
                            state_reg <= CHECK;
                        end
`else
                        if (last_word) begin
                            state_reg     <= HUNT;
                            busy_out      <= 1'b0;
                            done_pend_reg <= 1'b1;
                        end
`endif
                    end
`ifdef UART_FRAME_CHECKSUM_EN
                    CHECK: begin
                        state_reg <= HUNT;
                        busy_out  <= 1'b0;
                        if (rx_data_in == sum_reg) begin
                            frame_done_out <= 1'b1;
                            err_code_out   <= '0;
                        end else begin
                            frame_err_out <= 1'b1;
                            err_code_out  <= ERR_SUM;
                        end
                    end
`endif
                    default: begin
                        state_reg <= HUNT;
                        busy_out  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Sequences the word stream from the UART receiver (one `valid`/`data` pulse per received word) into framed commands.
- Hunts for a sync word, then reads a length word, forwards the payload words with their index, and checks a trailing checksum.
- Reports per-frame done/error status.
- Sits between the UART receiver and the command decoders.
- Aborts stalled frames with an inter-word timeout.

Parameters:
- WIDTH, 16: word width; must match the receiver's data width.
- SYNC_WORD, 16'hA55A: frame start marker, WIDTH bits.
- MAX_LEN, 64: largest legal payload length in words; must be at least 1.
- TIMEOUT_CYCLES, 2_000_000: idle clk_in cycles allowed between words inside a frame.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- rx_valid_in  input  1  one-cycle pulse: new received word.
- rx_data_in  input  WIDTH  received word; qualified by rx_valid_in.
- word_valid_out  output  1  one-cycle pulse: payload word available.
- word_data_out  output  WIDTH  payload word.
- word_index_out  output  $clog2(MAX_LEN)  payload word position, 0-based.
- frame_len_out  output  $clog2(MAX_LEN+1)  length of the current/last frame.
- frame_done_out  output  1  one-cycle pulse: frame ended cleanly.
- frame_err_out  output  1  one-cycle pulse: frame aborted.
- err_code_out  output  2  error cause: 1 = timeout, 2 = bad length, 3 = checksum mismatch; held until the next done or error.
- busy_out  output  1  high in any state other than HUNT.

Behaviour:
- Reset:
  - rst_in is asynchronous and active-high; it applies immediately, including mid-frame.
  - All outputs reset to 0; state resets to HUNT.
  - The sum, word counter and timeout counter reset to 0.
- All outputs are registered. Every response appears on the cycle after the qualifying rx_valid_in.
- States:
  - HUNT:
    - rx_valid_in with rx_data_in == SYNC_WORD moves to LEN.
    - Any other word is ignored silently, with no error pulse.
  - LEN, on rx_valid_in:
    - If 1 <= data <= MAX_LEN: latch frame_len_out, set sum = data, clear the index, move to PAYLOAD.
    - Otherwise: frame_err_out = 1, err_code_out = 2, move to HUNT.
  - PAYLOAD, on rx_valid_in:
    - Drive word_valid_out = 1 with word_data_out = data and word_index_out = current index.
    - Update sum = sum + data, modulo 2^WIDTH.
    - Increment the index.
    - After word number frame_len_out, move to CHECK.
  - CHECK, on rx_valid_in:
    - If data == sum: frame_done_out = 1, move to HUNT.
    - Otherwise: frame_err_out = 1, err_code_out = 3, move to HUNT.
- SYNC_WORD seen in LEN, PAYLOAD or CHECK is treated as ordinary data. There is no resynchronisation mid-frame.
- Timeout:
  - The counter runs in every state except HUNT and clears on each rx_valid_in.
  - When the count reaches TIMEOUT_CYCLES-1 without a word: frame_err_out = 1, err_code_out = 1, move to HUNT.
  - If rx_valid_in arrives on the same cycle the count reaches TIMEOUT_CYCLES-1, the word wins and no timeout occurs.
- Pulse rules:
  - frame_done_out and frame_err_out are never high together.
  - Each is exactly one cycle wide.
  - err_code_out clears to 0 when frame_done_out pulses.
- Back-to-back frames: a SYNC_WORD arriving on the cycle after a done or error pulse is accepted. No dead cycle is required.
- No backpressure: downstream logic must accept word_valid_out whenever it pulses.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- When defined:
  - The CHECK state and sum logic exist.
  - The frame is SYNC, LEN, payload, then checksum.
- When undefined:
  - There is no checksum word and no sum register.
  - After the last payload word: frame_done_out pulses on the cycle after that word's word_valid_out pulse (the word's own +1 latency, not a further cycle), and the state returns to HUNT.
  - err_code_out value 3 never occurs.

Test Plan:
- Good frame, checksum enabled:
  - Stimulus: words A55A, 0003, 0011, 0022, 0033, 0069.
  - Response: three word_valid_out pulses carrying 0011/0022/0033 at indices 0/1/2, frame_len_out = 3, then a single frame_done_out pulse.
- Checksum mismatch:
  - Stimulus: the same frame ending in 0068.
  - Response: three payload pulses, then frame_err_out with err_code_out = 3; the following A55A starts a new frame.
- Bad length:
  - Stimulus: A55A, 0000. Response: frame_err_out, err_code_out = 2.
  - Stimulus: A55A, 0041 (65, which exceeds MAX_LEN). Response: same error.
  - Neither case produces any word_valid_out pulse.
- Timeout (TIMEOUT_CYCLES = 100):
  - Stimulus: A55A, 0002, 1234, then silence.
  - Response: frame_err_out with err_code_out = 1 exactly 100 cycles after the 1234 pulse.
  - A word arriving on the boundary cycle suppresses the timeout.
- Noise and reset:
  - Words 1111 and 2222 in HUNT produce no outputs.
  - Asserting rst_in mid-payload clears all outputs asynchronously.
  - A complete frame after reset release is received correctly.
- Macro off:
  - Stimulus: A55A, 0002, BEEF, CAFE.
  - Response: two payload pulses, then frame_done_out on the cycle after the CAFE word_valid_out pulse.
